// File: rtl/node_mem_ctrl.sv
// node_mem_ctrl: requester side of the dual-port BDD node SRAM.
//   Port A: sequential node allocation (write), returns the assigned index.
//   Port B: read requests with a 2-entry fall-through response FIFO,
//           write-to-read forwarding and out-of-range flagging.
// Optional build macro: NODE_MEM_STATS_EN adds saturating 16-bit counters
//   stat_reads_o, stat_stalls_o and stat_errs_o.
module node_mem_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 34,
    parameter int DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clr_i,
    input  logic                  alloc_valid_i,
    output logic                  alloc_ready_o,
    input  logic [DATA_WIDTH-1:0] alloc_data_i,
    output logic                  alloc_done_o,
    output logic [ADDR_WIDTH-1:0] alloc_addr_o,
    output logic                  full_o,
    input  logic                  rd_req_valid_i,
    output logic                  rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr_i,
    output logic                  rd_rsp_valid_o,
    input  logic                  rd_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rd_rsp_data_o,
    output logic                  rd_rsp_err_o,
    output logic                  mem_we_a_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_a_o,
    output logic [DATA_WIDTH-1:0] mem_data_a_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_b_o,
    input  logic [DATA_WIDTH-1:0] mem_q_b_i
`ifdef NODE_MEM_STATS_EN
    ,
    output logic [15:0]           stat_reads_o,
    output logic [15:0]           stat_stalls_o,
    output logic [15:0]           stat_errs_o
`endif
);

    // The pointer needs one extra bit so that DEPTH == 2^ADDR_WIDTH is representable.
    localparam int                PTR_W   = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0]  DEPTH_C = PTR_W'(DEPTH);

    // Allocation state
    logic [PTR_W-1:0]      alloc_ptr_q, alloc_ptr_d;
    logic                  clr_pend_q, clr_pend_d;
    logic                  alloc_done_q;
    logic [ADDR_WIDTH-1:0] alloc_addr_q, alloc_addr_d;

    // In-flight read (SRAM has one cycle of read latency)
    logic                  inflight_q;
    logic                  if_fwd_q, if_fwd_d;
    logic                  if_err_q, if_err_d;
    logic [DATA_WIDTH-1:0] if_fwd_data_q, if_fwd_data_d;

    // Response FIFO, entries hold {err, data}
    logic [DATA_WIDTH:0]   fifo_q [2];
    logic                  fifo_wr_q, fifo_wr_d;
    logic                  fifo_rd_q, fifo_rd_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    // Combinational handshake terms
    logic                  alloc_acc;
    logic                  rd_acc;
    logic                  fwd_hit;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_err;
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_err;
    logic                  pop;
    logic                  push;
    logic                  fifo_pop;
    logic [2:0]            occ;

    assign full_o        = (alloc_ptr_q == DEPTH_C);
    assign alloc_ready_o = !full_o && !clr_i;
    assign alloc_done_o  = alloc_done_q;
    assign alloc_addr_o  = alloc_addr_q;

    assign mem_we_a_o    = alloc_acc;
    assign mem_addr_a_o  = alloc_ptr_q[ADDR_WIDTH-1:0];
    assign mem_data_a_o  = alloc_data_i;
    assign mem_addr_b_o  = rd_req_addr_i;

    assign rd_rsp_valid_o = head_valid;
    assign rd_rsp_data_o  = head_valid ? head_data : '0;
    assign rd_rsp_err_o   = head_valid && head_err;

    // Handshakes, forwarding/error classification and FIFO head selection
    always_comb begin
        alloc_acc = alloc_valid_i && alloc_ready_o;

        // The in-flight result enters the FIFO as it arrives; when the FIFO is
        // empty it falls straight through to the head for one-cycle latency.
        in_err  = if_err_q;
        in_data = '0;
        if (!if_err_q) begin
            in_data = if_fwd_q ? if_fwd_data_q : mem_q_b_i;
        end

        head_valid = 1'b0;
        head_err   = 1'b0;
        head_data  = '0;
        if (fifo_cnt_q != 2'd0) begin
            head_valid = 1'b1;
            {head_err, head_data} = fifo_q[fifo_rd_q];
        end else if (inflight_q) begin
            head_valid = 1'b1;
            head_err   = in_err;
            head_data  = in_data;
        end

        pop      = head_valid && rd_rsp_ready_i;
        fifo_pop = pop && (fifo_cnt_q != 2'd0);
        push     = inflight_q && !((fifo_cnt_q == 2'd0) && pop);

        // Credit: in-flight plus stored responses may never exceed two,
        // counting a pop that happens in the same cycle.
        occ            = 3'(inflight_q) + 3'(fifo_cnt_q);
        rd_req_ready_o = !clr_i && (occ < (3'd2 + 3'(pop)));
        rd_acc         = rd_req_valid_i && rd_req_ready_o;

        // SRAM returns stale data for a same-cycle write/read of one address.
        fwd_hit = rd_acc && alloc_acc && (rd_req_addr_i == alloc_ptr_q[ADDR_WIDTH-1:0]);
        req_err = !fwd_hit && ({1'b0, rd_req_addr_i} >= alloc_ptr_q);
    end

    // Next-state for allocation pointer, pending clear and done report
    always_comb begin
        alloc_ptr_d  = alloc_ptr_q;
        clr_pend_d   = clr_pend_q;
        alloc_addr_d = alloc_addr_q;
        if (alloc_acc) begin
            alloc_addr_d = alloc_ptr_q[ADDR_WIDTH-1:0];
        end
        // A clear waits for the in-flight read so its error verdict stays valid.
        if (clr_i || clr_pend_q) begin
            if (!inflight_q) begin
                alloc_ptr_d = '0;
                clr_pend_d  = 1'b0;
            end else begin
                clr_pend_d  = 1'b1;
            end
        end else if (alloc_acc) begin
            alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
        end
    end

    // Next-state for the in-flight capture and FIFO pointers
    always_comb begin
        if_fwd_d      = if_fwd_q;
        if_err_d      = if_err_q;
        if_fwd_data_d = if_fwd_data_q;
        if (rd_acc) begin
            if_fwd_d      = fwd_hit;
            if_err_d      = req_err;
            if_fwd_data_d = alloc_data_i;
        end

        fifo_wr_d  = push     ? ~fifo_wr_q : fifo_wr_q;
        fifo_rd_d  = fifo_pop ? ~fifo_rd_q : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(fifo_pop);
    end

    // Allocation registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            alloc_ptr_q  <= '0;
            clr_pend_q   <= 1'b0;
            alloc_done_q <= 1'b0;
            alloc_addr_q <= '0;
        end else begin
            alloc_ptr_q  <= alloc_ptr_d;
            clr_pend_q   <= clr_pend_d;
            alloc_done_q <= alloc_acc;
            alloc_addr_q <= alloc_addr_d;
        end
    end

    // Read pipeline control registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            inflight_q    <= 1'b0;
            if_fwd_q      <= 1'b0;
            if_err_q      <= 1'b0;
            if_fwd_data_q <= '0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            inflight_q    <= rd_acc;
            if_fwd_q      <= if_fwd_d;
            if_err_q      <= if_err_d;
            if_fwd_data_q <= if_fwd_data_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // FIFO storage; contents are only visible through the count, so no reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[fifo_wr_q] <= {in_err, in_data};
        end
    end

`ifdef NODE_MEM_STATS_EN
    logic [15:0] stat_reads_q;
    logic [15:0] stat_stalls_q;
    logic [15:0] stat_errs_q;

    assign stat_reads_o  = stat_reads_q;
    assign stat_stalls_o = stat_stalls_q;
    assign stat_errs_o   = stat_errs_q;

    // Saturating activity counters
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stat_reads_q  <= '0;
            stat_stalls_q <= '0;
            stat_errs_q   <= '0;
        end else begin
            if (rd_acc && (stat_reads_q != '1)) begin
                stat_reads_q <= stat_reads_q + 16'd1;
            end
            if (rd_req_valid_i && !rd_req_ready_o && (stat_stalls_q != '1)) begin
                stat_stalls_q <= stat_stalls_q + 16'd1;
            end
            if (inflight_q && if_err_q && (stat_errs_q != '1)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/node_mem_ctrl.md
Name: node_mem_ctrl

Overview:
- Initiator/controller for the BDD node table: the requester side of the dual-port node SRAM (port A write, port B read, one-cycle registered read).
- Allocates new nodes sequentially through port A and returns the assigned index.
- Serves read requests through port B with a valid/ready response channel, a 2-entry response buffer, write-to-read forwarding and out-of-range flagging.
- Sits between the BDD apply/reduce engines and the node SRAM.

Parameters:
- ADDR_WIDTH, 8, node index width; matches the SRAM address width.
- DATA_WIDTH, 34, node word width; opaque to this block.
- DEPTH, 8, number of node slots; must be <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  pulse; empties the node table (alloc_ptr back to 0).
- alloc_valid  in  1  allocation request.
- alloc_ready  out  1  allocation accepted this cycle when high with alloc_valid.
- alloc_data  in  DATA_WIDTH  node word to store.
- alloc_done  out  1  one-cycle pulse, the cycle after acceptance.
- alloc_addr  out  ADDR_WIDTH  index written; valid with alloc_done.
- full  out  1  alloc_ptr == DEPTH.
- rd_req_valid  in  1  read request.
- rd_req_ready  out  1  read accepted when high with rd_req_valid.
- rd_req_addr  in  ADDR_WIDTH  node index to read.
- rd_rsp_valid  out  1  response available.
- rd_rsp_ready  in  1  consumer accepts the response.
- rd_rsp_data  out  DATA_WIDTH  node word.
- rd_rsp_err  out  1  requested index >= alloc_ptr at request time; data is then all zeros.
- mem_we_a  out  1  to SRAM we_a.
- mem_addr_a  out  ADDR_WIDTH  to SRAM addr_a.
- mem_data_a  out  DATA_WIDTH  to SRAM data_a.
- mem_addr_b  out  ADDR_WIDTH  to SRAM addr_b.
- mem_q_b  in  DATA_WIDTH  from SRAM q_b; valid one cycle after mem_addr_b.

Behaviour:
- Reset (rst_n low at a clock edge):
  - alloc_ptr = 0; alloc_done = 0; alloc_addr = 0; full = 0.
  - Response buffer emptied; in-flight read dropped; rd_rsp_valid = 0, rd_rsp_data = 0, rd_rsp_err = 0.
  - mem_we_a = 0.
  - Reset mid-transaction discards everything; no alloc_done and no response are produced afterwards.
- Allocation:
  - alloc_ready = !full && !clr.
  - On acceptance, drive mem_we_a = 1, mem_addr_a = alloc_ptr, mem_data_a = alloc_data combinationally in the same cycle.
  - The next cycle: alloc_done = 1, alloc_addr = old alloc_ptr, and alloc_ptr has incremented.
  - Throughput is one allocation per cycle.
  - At alloc_ptr == DEPTH: full = 1 and requests are held off; there is no wrap-around.
  - mem_we_a is 0 whenever no allocation is accepted.
- Read pipeline:
  - mem_addr_b = rd_req_addr continuously.
  - An accepted request sets an in-flight flag. The next cycle, the result is pushed into a 2-entry FIFO:
    - mem_q_b normally;
    - forwarded data when flagged;
    - zeros if err.
  - Credit rule: rd_req_ready = !clr && (inflight + fifo_count < 2), evaluated with the same-cycle pop counted. A pop happens when rd_rsp_valid && rd_rsp_ready.
  - Result: a sustained one read per cycle with rd_rsp_ready held high, and no loss under backpressure.
  - rd_rsp_valid = FIFO non-empty. Head data and err stay stable while valid && !ready.
  - Latency: request accepted at cycle N gives the response valid at N+1 when the FIFO is empty.
- Forwarding:
  - The SRAM returns old data when reading an address written in the same cycle.
  - If a read and an allocation are accepted in the same cycle with rd_req_addr == alloc_ptr, capture alloc_data and return it. err = 0 in this case.
- Error check: err is computed at acceptance as rd_req_addr >= alloc_ptr (excluding the forwarding case).
- Clear:
  - clr blocks new requests that cycle.
  - If inflight == 0, alloc_ptr becomes 0 next cycle.
  - Otherwise the clear is held pending until inflight == 0.
  - Clear does not flush the FIFO. SRAM contents are not erased.

Optional Feature:
- Macro: NODE_MEM_STATS_EN.
- When defined, three outputs are added, all reset to 0 and saturating at all-ones:
  - stat_reads (16 bits): increments per accepted read.
  - stat_stalls (16 bits): increments per cycle with rd_req_valid && !rd_req_ready.
  - stat_errs (16 bits): increments per err response pushed.
- When not defined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Allocation: reset, then allocate 8 words 0x3_0000_0000+i back-to-back.
  - Required: alloc_addr 0..7, one alloc_done pulse each, full = 1 after the 8th.
  - A 9th alloc_valid sees alloc_ready = 0 and mem_we_a stays 0.
- Streaming read: read addrs 0..7 with rd_rsp_ready = 1.
  - Required: responses in order at 1/cycle, data matches, err = 0, first response 1 cycle after the first request.
- Backpressure: stream reads while rd_rsp_ready is low for 5 cycles.
  - Required: rd_req_ready drops after 2 accepts, no responses lost or reordered, head stable while stalled.
- Forwarding: with alloc_ptr = 3, allocate 0x1234 and read addr 3 in the same cycle.
  - Required: response data = 0x1234, err = 0.
- Out of range: with alloc_ptr = 2, read addr 5.
  - Required: rd_rsp_err = 1, data = 0.
- Clear and reset: assert clr with a read in flight, and separately assert rst_n low mid-stream.
  - clr: the in-flight response is still delivered, alloc_ptr = 0 afterwards, and the next allocation gets addr 0.
  - Reset: all outputs return to their reset values and no stale response appears.
